// File: rtl/fifo_push_ctrl_if.sv
// Handshake bundle for the write-side producer: upstream valid/ready words
// in, FIFO write port (winc/wdata with wfull status) out.
interface fifo_push_ctrl_if #(
   parameter int DATASIZE = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [DATASIZE-1:0] in_data;
   logic                in_last;
   logic                wfull;
   logic                wfull_almost;
   logic                winc;
   logic [DATASIZE-1:0] wdata;

   modport master (
      input  in_valid, in_data, in_last, wfull, wfull_almost,
      output in_ready, winc, wdata
   );

   modport slave (
      output in_valid, in_data, in_last, wfull, wfull_almost,
      input  in_ready, winc, wdata
   );
endinterface

// File: rtl/fifo_push_ctrl.sv
// Write-domain producer for the async FIFO: 2-entry skid buffer feeding
// winc/wdata, with packet framing status, counters and a sticky protocol flag.
module fifo_push_ctrl #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 8,
   parameter int PKTCNT_W = 16
) (
   input  logic                wclk,
   input  logic                wrst_n,
   fifo_push_ctrl_if.master    bus,
   input  logic                flush,
   input  logic                err_clr,
   output logic                pkt_open,
   output logic                pkt_done,
   output logic [PKTCNT_W-1:0] pkt_cnt,
   output logic [ADDRSIZE:0]   wr_words,
   output logic                stall,
   output logic                proto_err
);

   typedef struct packed {
      logic [DATASIZE-1:0] data;
      logic                last;
      logic                valid;
   } entry_t;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OPEN = 1'b1;

   entry_t              head_q, tail_q, head_d, tail_d, in_entry;
   logic                in_ready_q;
   logic                accept, pop, violation;
   logic [0:0]          state_q, state_d;
   logic                pend_q;
   logic [DATASIZE-1:0] pend_data_q;
   logic                pend_last_q;
   logic                unused_almost;

   // wfull_almost is FIFO-side status only; stalling relies on wfull alone.
   assign unused_almost = bus.wfull_almost;

   assign bus.in_ready = in_ready_q & ~flush;
   assign accept       = bus.in_valid & bus.in_ready;
   assign pop          = head_q.valid & ~bus.wfull & ~flush;
   assign bus.winc     = pop;
   assign bus.wdata    = head_q.data;
   assign stall        = head_q.valid & bus.wfull;
   assign pkt_done     = pop & head_q.last;
   assign pkt_open     = (state_q == ST_OPEN);
   assign in_entry     = {bus.in_data, bus.in_last, 1'b1};

   assign violation = pend_q & (~bus.in_valid
                                | (bus.in_data != pend_data_q)
                                | (bus.in_last != pend_last_q));

   always_comb begin
      // NOTE: defaults first so every path assigns head_d/tail_d and no latch is inferred.
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         head_d.valid = 1'b0;
         tail_d.valid = 1'b0;
      end else begin
         if (pop) begin
            head_d       = tail_q;
            tail_d.valid = 1'b0;
         end
         // Applied after the pop shift so a word arriving on a pop lands in order.
         if (accept) begin
            if (!head_d.valid) head_d = in_entry;
            else               tail_d = in_entry;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush)    state_d = ST_IDLE;
      else if (pop) state_d = head_q.last ? ST_IDLE : ST_OPEN;
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         // NOTE: the two data entries are only two words, so they are reset too and wdata reads 0 out of reset.
         head_q      <= '0;
         tail_q      <= '0;
         in_ready_q  <= 1'b0;
         state_q     <= ST_IDLE;
         pkt_cnt     <= '0;
         wr_words    <= '0;
         proto_err   <= 1'b0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
         pend_last_q <= 1'b0;
      end else begin
         // NOTE: all state updates use <= so every register samples pre-edge values.
         head_q  <= head_d;
         tail_q  <= tail_d;
         state_q <= state_d;
         // TAIL is only ever valid behind a valid HEAD, so an empty TAIL means occupancy <= 1.
         in_ready_q <= ~tail_d.valid;
         if (pop)      wr_words <= wr_words + {{ADDRSIZE{1'b0}}, 1'b1};
         if (pkt_done) pkt_cnt  <= pkt_cnt + {{(PKTCNT_W-1){1'b0}}, 1'b1};
         pend_q      <= bus.in_valid & ~bus.in_ready;
         pend_data_q <= bus.in_data;
         pend_last_q <= bus.in_last;
         if (violation)    proto_err <= 1'b1;
         else if (err_clr) proto_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_push_ctrl.sv
// Self-checking bench for fifo_push_ctrl: a queue-based reference model of the
// skid buffer, framing, counters and protocol rules, driven by directed and random traffic.
module tb_fifo_push_ctrl;

   logic        wclk;
   logic        wrst_n;
   logic        flush;
   logic        err_clr;
   logic        pkt_open, pkt_done, stall, proto_err;
   logic [15:0] pkt_cnt;
   logic [8:0]  wr_words;

   fifo_push_ctrl_if #(.DATASIZE(8)) ifc();

   fifo_push_ctrl #(.DATASIZE(8), .ADDRSIZE(8), .PKTCNT_W(16)) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .bus       (ifc),
      .flush     (flush),
      .err_clr   (err_clr),
      .pkt_open  (pkt_open),
      .pkt_done  (pkt_done),
      .pkt_cnt   (pkt_cnt),
      .wr_words  (wr_words),
      .stall     (stall),
      .proto_err (proto_err)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int nvec = 0;
   int nerr = 0;

   logic [38:0] obs;
   assign obs = {ifc.in_ready, ifc.winc, ifc.wdata, pkt_open, pkt_done,
                 pkt_cnt, wr_words, stall, proto_err};

   // Reference model: accepted words wait in a queue, head of queue is the next write.
   logic [8:0]  mq[$];
   logic        m_ready = 1'b0;
   logic        m_open  = 1'b0;
   logic [15:0] m_pkt   = '0;
   logic [8:0]  m_words = '0;
   logic        m_perr  = 1'b0;
   logic        m_pend  = 1'b0;
   logic [7:0]  m_pdata = '0;
   logic        m_plast = 1'b0;
   logic        m_rdy, m_w, m_acc, m_viol;
   logic [8:0]  m_e;

   always @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         mq.delete();
         m_ready = 1'b0; m_open = 1'b0; m_pkt = '0; m_words = '0;
         m_perr  = 1'b0; m_pend = 1'b0;
      end else begin
         m_rdy  = m_ready && !flush;
         m_w    = (mq.size() != 0) && !ifc.wfull && !flush;
         m_acc  = ifc.in_valid && m_rdy;
         m_viol = m_pend && (!ifc.in_valid || ifc.in_data != m_pdata || ifc.in_last != m_plast);
         if (flush) begin
            mq.delete();
            m_open = 1'b0;
         end else begin
            if (m_w) begin
               m_e = mq.pop_front();
               m_words = m_words + 9'd1;
               if (m_e[8]) begin m_pkt = m_pkt + 16'd1; m_open = 1'b0; end
               else m_open = 1'b1;
            end
            if (m_acc) mq.push_back({ifc.in_last, ifc.in_data});
         end
         m_ready = (mq.size() <= 1);
         m_pend  = ifc.in_valid && !m_rdy;
         m_pdata = ifc.in_data;
         m_plast = ifc.in_last;
         if (m_viol)       m_perr = 1'b1;
         else if (err_clr) m_perr = 1'b0;
      end
   end

   logic [38:0] exp_vec, exp_mask;
   logic        exp_ready, exp_winc;

   function automatic void calc_exp();
      logic [8:0] h;
      h         = (mq.size() != 0) ? mq[0] : 9'h0;
      exp_ready = m_ready && !flush;
      exp_winc  = (mq.size() != 0) && !ifc.wfull && !flush;
      exp_vec   = {exp_ready, exp_winc, h[7:0], m_open, exp_winc && h[8],
                   m_pkt, m_words, (mq.size() != 0) && ifc.wfull, m_perr};
      exp_mask  = {2'b11, (mq.size() != 0) ? 8'hFF : 8'h00, 29'h1FFF_FFFF};
   endfunction

   logic [7:0] got_q[$];
   logic [8:0] src_q[$];
   bit         holding = 1'b0;

   task automatic cycle(input bit v, input logic [7:0] d, input bit l,
                        input bit wf, input bit wa, input bit fl, input bit ec);
      @(negedge wclk);
      ifc.in_valid = v; ifc.in_data = d; ifc.in_last = l;
      ifc.wfull = wf; ifc.wfull_almost = wa; flush = fl; err_clr = ec;
      #1;
      calc_exp();
      if (ifc.winc === 1'b1) got_q.push_back(ifc.wdata);
   endtask

   // Compliant upstream source: holds an offered word until it is taken.
   task automatic tick(input bit allow, input bit wf, input bit wa, input bit fl, input bit ec);
      bit         v;
      logic [8:0] w;
      v = holding || (allow && src_q.size() != 0);
      w = (src_q.size() != 0) ? src_q[0] : 9'h0;
      cycle(v, w[7:0], w[8], wf, wa, fl, ec);
      if (v) begin
         if (exp_ready) begin void'(src_q.pop_front()); holding = 1'b0; end
         else holding = 1'b1;
      end
   endtask

   task automatic test_reset();
      wrst_n = 1'b0;
      repeat (2) @(negedge wclk);
      #1;
      nvec++; if (obs !== 39'h0) begin nerr++; $display("FAIL reset_vals obs=%h exp=0", obs); end
      @(negedge wclk);
      wrst_n = 1'b1;
      #1;
      nvec++; if (ifc.in_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready_low got=%b exp=0", ifc.in_ready); end
      cycle(0, 8'h00, 0, 0, 0, 0, 0);
      nvec++; if (ifc.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready_rise got=%b exp=1", ifc.in_ready); end
      nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL reset_model obs=%h exp=%h", obs, exp_vec); end
   endtask

   task automatic test_stream();
      int first_acc = -1, first_w = -1, last_w = -1;
      got_q.delete();
      for (int i = 0; i < 5; i++) src_q.push_back({i == 4, 8'(8'h11 + i)});
      for (int c = 0; c < 10; c++) begin
         tick(1, 0, 0, 0, 0);
         nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL stream c%0d obs=%h exp=%h", c, obs, exp_vec); end
         if (first_acc < 0 && ifc.in_valid && exp_ready) first_acc = c;
         if (ifc.winc === 1'b1) begin if (first_w < 0) first_w = c; last_w = c; end
      end
      nvec++; if (got_q.size() != 5) begin nerr++; $display("FAIL stream_count got=%0d exp=5", got_q.size()); end
      for (int k = 0; k < 5 && k < got_q.size(); k++) begin
         nvec++; if (got_q[k] !== 8'(8'h11 + k)) begin nerr++; $display("FAIL stream_data%0d got=%h exp=%h", k, got_q[k], 8'h11 + k); end
      end
      nvec++; if (first_w != first_acc + 1 || last_w - first_w != 4) begin
         nerr++; $display("FAIL stream_latency first_w=%0d last_w=%0d exp first=%0d span=4", first_w, last_w, first_acc + 1); end
      nvec++; if (wr_words !== 9'd5) begin nerr++; $display("FAIL stream_words got=%0d exp=5", wr_words); end
      nvec++; if (pkt_cnt !== 16'd1) begin nerr++; $display("FAIL stream_pkts got=%0d exp=1", pkt_cnt); end
   endtask

   task automatic test_wfull_stall();
      got_q.delete();
      src_q.push_back({1'b0, 8'h21}); src_q.push_back({1'b0, 8'h22}); src_q.push_back({1'b1, 8'h23});
      for (int c = 0; c < 6; c++) begin
         tick(1, 1, 0, 0, 0);
         nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL stall c%0d obs=%h exp=%h", c, obs, exp_vec); end
         nvec++; if (ifc.winc !== 1'b0 || (c >= 1 && stall !== 1'b1) || (c >= 2 && ifc.in_ready !== 1'b0)) begin
            nerr++; $display("FAIL stall_hold c%0d winc=%b stall=%b in_ready=%b exp 0/1/0", c, ifc.winc, stall, ifc.in_ready); end
      end
      for (int c = 0; c < 6; c++) begin
         tick(1, 0, 0, 0, 0);
         nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL release c%0d obs=%h exp=%h", c, obs, exp_vec); end
         if (c < 2) begin
            nvec++; if (ifc.winc !== 1'b1) begin nerr++; $display("FAIL release_b2b c%0d winc=%b exp=1", c, ifc.winc); end
         end
      end
      nvec++; if (got_q.size() != 3 || got_q[0] !== 8'h21 || got_q[1] !== 8'h22 || got_q[2] !== 8'h23) begin
         nerr++; $display("FAIL release_order got n=%0d %p exp 21 22 23", got_q.size(), got_q); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] sent[$];
      int drops = 0;
      logic [8:0] w0;
      w0 = m_words;
      got_q.delete();
      for (int i = 0; i < 300; i++) begin
         sent.push_back(8'(i * 7 + 3));
         src_q.push_back({(i % 10) == 9, 8'(i * 7 + 3)});
      end
      for (int c = 0; c < 320; c++) begin
         tick(1, 0, 0, 0, 0);
         nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL b2b c%0d obs=%h exp=%h", c, obs, exp_vec); end
         if (ifc.in_ready !== 1'b1) drops++;
         if (src_q.size() == 0 && mq.size() == 0) break;
      end
      nvec++; if (drops != 0) begin nerr++; $display("FAIL b2b_ready_drops got=%0d exp=0", drops); end
      nvec++; if (got_q.size() != 300) begin nerr++; $display("FAIL b2b_count got=%0d exp=300", got_q.size()); end
      for (int k = 0; k < 300 && k < got_q.size(); k++) begin
         nvec++; if (got_q[k] !== sent[k]) begin nerr++; $display("FAIL b2b_data%0d got=%h exp=%h", k, got_q[k], sent[k]); end
      end
      nvec++; if (wr_words !== 9'((w0 + 300) % 512)) begin
         nerr++; $display("FAIL b2b_words got=%0d exp=%0d", wr_words, (w0 + 300) % 512); end
   endtask

   task automatic test_proto_err();
      logic [3:0] exp_pe;
      // Withdrawn offer.
      cycle(1, 8'h01, 0, 1, 0, 0, 0);
      cycle(1, 8'h02, 0, 1, 0, 0, 0);
      cycle(1, 8'hAA, 0, 1, 0, 0, 0);
      nvec++; if (ifc.in_ready !== 1'b0) begin nerr++; $display("FAIL proto_ready got=%b exp=0", ifc.in_ready); end
      cycle(0, 8'hAA, 0, 1, 0, 0, 0);
      nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL proto_pre got=%b exp=0", proto_err); end
      for (int c = 0; c < 3; c++) begin
         cycle(0, 8'h00, 0, 1, 0, 0, 0);
         nvec++; if (proto_err !== 1'b1) begin nerr++; $display("FAIL proto_sticky c%0d got=%b exp=1", c, proto_err); end
      end
      cycle(0, 8'h00, 0, 1, 0, 0, 1);
      nvec++; if (proto_err !== 1'b1) begin nerr++; $display("FAIL proto_clr_cycle got=%b exp=1", proto_err); end
      cycle(0, 8'h00, 0, 1, 0, 0, 0);
      nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL proto_cleared got=%b exp=0", proto_err); end
      for (int c = 0; c < 3; c++) cycle(0, 8'h00, 0, 0, 0, 0, 0);
      // Data changed under stall, then a second change while clearing: set wins.
      cycle(1, 8'h03, 0, 1, 0, 0, 0);
      cycle(1, 8'h04, 0, 1, 0, 0, 0);
      cycle(1, 8'hAA, 0, 1, 0, 0, 0);
      exp_pe = 4'b1100;
      cycle(1, 8'hAB, 0, 1, 0, 0, 0);
      nvec++; if (proto_err !== exp_pe[0]) begin nerr++; $display("FAIL proto_chg_pre got=%b exp=%b", proto_err, exp_pe[0]); end
      cycle(1, 8'hAC, 0, 1, 0, 0, 1);
      nvec++; if (proto_err !== exp_pe[2]) begin nerr++; $display("FAIL proto_chg_set got=%b exp=%b", proto_err, exp_pe[2]); end
      cycle(1, 8'hAC, 0, 0, 0, 0, 1);
      nvec++; if (proto_err !== exp_pe[3]) begin nerr++; $display("FAIL proto_set_wins got=%b exp=%b", proto_err, exp_pe[3]); end
      cycle(1, 8'hAC, 0, 0, 0, 0, 0);
      nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL proto_chg_clr got=%b exp=0", proto_err); end
      nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL proto_model obs=%h exp=%h", obs, exp_vec); end
      for (int c = 0; c < 4; c++) begin
         cycle(0, 8'h00, 0, 0, 0, 0, 0);
         nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL proto_drain c%0d obs=%h exp=%h", c, obs, exp_vec); end
      end
   endtask

   task automatic test_flush();
      logic [8:0] w_before;
      cycle(1, 8'h31, 0, 0, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 0, 0, 0);
      cycle(1, 8'h32, 0, 1, 0, 0, 0);
      cycle(1, 8'h33, 0, 1, 0, 0, 0);
      cycle(0, 8'h00, 0, 1, 0, 0, 0);
      w_before = wr_words;
      nvec++; if (pkt_open !== 1'b1 || stall !== 1'b1) begin nerr++; $display("FAIL flush_setup open=%b stall=%b exp 1/1", pkt_open, stall); end
      got_q.delete();
      cycle(1, 8'h5A, 1, 0, 0, 1, 0);
      nvec++; if (ifc.winc !== 1'b0 || ifc.in_ready !== 1'b0) begin
         nerr++; $display("FAIL flush_cycle winc=%b in_ready=%b exp 0/0", ifc.winc, ifc.in_ready); end
      nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL flush_model obs=%h exp=%h", obs, exp_vec); end
      cycle(1, 8'h5A, 1, 0, 0, 0, 0);
      nvec++; if (ifc.in_ready !== 1'b1 || pkt_open !== 1'b0 || ifc.winc !== 1'b0 || wr_words !== w_before) begin
         nerr++; $display("FAIL flush_after in_ready=%b open=%b winc=%b words=%0d exp 1/0/0/%0d",
                          ifc.in_ready, pkt_open, ifc.winc, wr_words, w_before); end
      for (int c = 0; c < 3; c++) begin
         cycle(0, 8'h00, 0, 0, 0, 0, 0);
         nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL flush_drain c%0d obs=%h exp=%h", c, obs, exp_vec); end
      end
      nvec++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin nerr++; $display("FAIL flush_written got %p exp 5a only", got_q); end
   endtask

   task automatic test_reset_mid();
      cycle(1, 8'h41, 0, 0, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 0, 0, 0);
      cycle(1, 8'h42, 0, 1, 0, 0, 0);
      cycle(0, 8'h00, 0, 1, 0, 0, 0);
      nvec++; if (stall !== 1'b1 || pkt_open !== 1'b1) begin nerr++; $display("FAIL rstmid_setup stall=%b open=%b exp 1/1", stall, pkt_open); end
      #2 wrst_n = 1'b0;
      #1;
      nvec++; if (obs !== 39'h0) begin nerr++; $display("FAIL rstmid_vals obs=%h exp=0", obs); end
      @(negedge wclk);
      wrst_n = 1'b1;
      holding = 1'b0; src_q.delete(); got_q.delete();
      for (int c = 0; c < 4; c++) begin
         cycle(0, 8'h00, 0, 0, 0, 0, 0);
         nvec++; if (ifc.winc !== 1'b0) begin nerr++; $display("FAIL rstmid_stale c%0d winc=%b exp=0", c, ifc.winc); end
         nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL rstmid_model c%0d obs=%h exp=%h", c, obs, exp_vec); end
      end
   endtask

   task automatic test_random();
      int fcnt = 0;
      bit wf, wa, fl, ec, allow;
      for (int c = 0; c < 600; c++) begin
         wf = (fcnt == 4);
         wa = (fcnt == 3);
         fl = ($urandom_range(0, 39) == 0);
         ec = ($urandom_range(0, 49) == 0);
         allow = ($urandom_range(0, 3) != 0);
         if (src_q.size() < 2) src_q.push_back({$urandom_range(0, 3) == 0, 8'($urandom)});
         // Occasionally misbehave upstream so the protocol checker sees traffic.
         if (holding && $urandom_range(0, 59) == 0) begin holding = 1'b0; void'(src_q.pop_front()); end
         tick(allow, wf, wa, fl, ec);
         nvec++; if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin nerr++; $display("FAIL random c%0d obs=%h exp=%h", c, obs, exp_vec); end
         if (exp_winc) fcnt++;
         else if (fcnt > 0 && $urandom_range(0, 1) == 1) fcnt--;
      end
   endtask

   initial begin
      wrst_n = 1'b0;
      flush = 1'b0; err_clr = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_last = 1'b0;
      ifc.wfull = 1'b0; ifc.wfull_almost = 1'b0;
      test_reset();
      test_stream();
      test_wfull_stall();
      test_back_to_back();
      test_proto_err();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fifo_push_ctrl.md
Name: fifo_push_ctrl

Overview:
Write-domain producer for the async FIFO: the sending end of the winc/wfull interface. Accepts words from an upstream valid/ready source through a 2-entry skid buffer and issues winc/wdata into the FIFO write port. Never writes while wfull is high. Provides packet framing status, counters and a sticky upstream-protocol error flag.

Parameters:
DATASIZE, 8, width of data word
ADDRSIZE, 8, FIFO address width; wr_words is ADDRSIZE+1 bits
PKTCNT_W, 16, width of packet counter

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream word valid
in_ready  out  1  upstream ready (registered)
in_data  in  DATASIZE  upstream word
in_last  in  1  last word of packet
flush  in  1  synchronous discard of buffered words
err_clr  in  1  clears proto_err
wfull  in  1  FIFO full (registered, from write-pointer logic)
wfull_almost  in  1  FIFO one-from-full
winc  out  1  FIFO write strobe
wdata  out  DATASIZE  FIFO write data
pkt_open  out  1  a packet has started but its last word is not yet written
pkt_done  out  1  one-cycle pulse when a last word is written
pkt_cnt  out  PKTCNT_W  packets written, wraps
wr_words  out  ADDRSIZE+1  words written, wraps mod 2^(ADDRSIZE+1)
stall  out  1  head valid and blocked by wfull
proto_err  out  1  sticky upstream protocol violation

Behaviour:
- Reset (async, wrst_n low): skid entries invalid; in_ready=0 while in reset, 1 on the first clock after release. winc=0, wdata=0, pkt_open=0, pkt_done=0, pkt_cnt=0, wr_words=0, stall=0, proto_err=0.
- Skid buffer: entries HEAD and TAIL, each holding {data,last,valid}. Occupancy is 0..2.
- Accept = in_valid & in_ready. Pop = winc.
- in_ready (registered) = 1 when next-cycle occupancy is 0 or 1.
- Order is preserved. Accept and pop in the same cycle with occupancy 1: the new word becomes HEAD and occupancy stays 1.
- Occupancy 2 with pop and no accept: TAIL moves to HEAD.
- Latency: a word accepted in cycle N with an empty buffer and wfull=0 produces winc in cycle N+1.
- Output port: winc = HEAD.valid & ~wfull & ~flush, combinational from registered wfull. wdata = HEAD.data, held stable while HEAD is valid.
- winc is never high while wfull=1.
- wfull_almost is status only: when wfull_almost=1 and winc fires, the bench must see wfull=1 on the next cycle (FIFO-side behaviour). The controller stalls correctly either way.
- stall = HEAD.valid & wfull.
- State machine, tracking packet framing of popped words:
  - IDLE: pkt_open=0. A pop with last=0 goes to OPEN. A pop with last=1 pulses pkt_done and stays in IDLE.
  - OPEN: pkt_open=1. A pop with last=1 goes to IDLE and pulses pkt_done.
  - Any state with flush=1 goes to IDLE.
- Counters:
  - wr_words increments by 1 on each winc and wraps to 0 after 2^(ADDRSIZE+1)-1.
  - pkt_cnt increments on each pkt_done and wraps.
- flush (single cycle):
  - Invalidates both entries.
  - Forces winc=0 and in_ready=0 for that cycle; in_ready=1 the next cycle.
  - Counters are unchanged. A word offered during flush is not accepted.
- proto_err is set in either of these cases:
  - (a) In the previous cycle in_valid=1 & in_ready=0, and in the current cycle in_valid=0 (valid withdrawn before acceptance).
  - (b) Same prior condition, and in_data or in_last changed while still unaccepted.
  - proto_err stays set until err_clr=1. If err_clr and a new violation occur in the same cycle, the set wins. proto_err does not block the datapath.
- Reset mid-operation: buffered words are discarded, counters and state are cleared, and no winc is issued during reset.

Test Plan:
1. Reset, then stream 5 words 0x11..0x15 (last on 0x15) with wfull=0 -> winc high for 5 consecutive cycles starting 1 cycle after the first accept; wdata in order; pkt_done on the 0x15 write; pkt_cnt=1; wr_words=5; pkt_open=1 between the 0x11 and 0x15 writes.
2. Hold wfull=1 for 6 cycles while streaming -> in_ready falls after 2 words buffered; winc=0 and stall=1 throughout; on wfull release the 2 buffered words write on consecutive cycles with no loss or duplication.
3. Simultaneous accept and pop every cycle for 300 words, ADDRSIZE=8 -> wr_words wraps correctly (300 mod 512 = 300); data order intact; occupancy never exceeds 1.
4. Offer 0xAA with in_ready=0, then drop in_valid -> proto_err=1 the next cycle; it stays 1 until err_clr, then returns to 0. In a separate run, change data 0xAA->0xAB under stall -> proto_err=1.
5. Buffer 2 words mid-packet and pulse flush -> winc=0 that cycle; pkt_open=0; next cycle in_ready=1; wr_words unchanged.
6. Assert wrst_n=0 mid-packet with HEAD valid and wfull=1 -> all outputs at reset values immediately; after release no stale word is written.
